// File: rtl/ram8_bank.sv
// ram8_bank: eight-entry register bank with a one-hot demux write strobe,
// a combinational 8:1 read select, and a sweep sequencer that zeroes
// the entries in order 0..7, one entry per cycle.
module ram8_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             drop,
  output logic [7:0]       wr_sel
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic             r_busy;
  logic             r_drop;
  logic [WIDTH-1:0] r_mem [8];

  logic             w_wr_en;
  logic [7:0]       w_wr_sel;

  // Write strobe: a load is honoured only while idle and not pre-empted by clear.
  always_comb begin
    w_wr_en  = load & ~r_busy & ~clear;
    w_wr_sel = 8'b0;
    if (w_wr_en) begin
      w_wr_sel[address] = 1'b1;
    end
  end

  // Sweep FSM, entry writes, and the registered busy/drop flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the entries sit in flops rather than a RAM macro because the
      // bank must read back zero right after reset, so they are reset here.
      for (int i = 0; i < 8; i++) begin
        r_mem[i] <= '0;
      end
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the later, more specific
      // assignments below override this default within the same edge.
      r_drop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state <= SWEEP;
            r_ptr   <= 3'd0;
            r_busy  <= 1'b1;
            r_drop  <= load;
          end else begin
            for (int i = 0; i < 8; i++) begin
              if (w_wr_sel[i]) begin
                r_mem[i] <= in;
              end
            end
          end
        end
        SWEEP: begin
          r_mem[r_ptr] <= '0;
          r_ptr        <= r_ptr + 3'd1;
          r_drop       <= load;
          if (r_ptr == 3'd7) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out    = r_mem[address];
  assign busy   = r_busy;
  assign drop   = r_drop;
  assign wr_sel = w_wr_sel;

endmodule

// File: tb/tb_ram8_bank.sv
// tb_ram8_bank: directed vectors for ram8_bank. A table covers plain
// writes and reads; hand-written sequences cover the sweep, its conflicts
// and a reset in the middle of a sweep.
module tb_ram8_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] dout;
  logic        busy;
  logic        drop;
  logic [7:0]  wr_sel;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt;

  ram8_bank #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .in      (din),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (dout),
    .busy    (busy),
    .drop    (drop),
    .wr_sel  (wr_sel)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        load;
    logic [2:0]  addr;
    logic [15:0] din;
    logic [7:0]  exp_sel;  // wr_sel before the edge
    logic [15:0] exp_out;  // entry[addr] after the edge
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Step while counting the cycles in which busy is seen high.
  task automatic sweep_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (busy) busy_cnt++;
    end
  endtask

  // Step until busy falls, bounded so a stuck sweep cannot hang the run.
  task automatic finish_sweep();
    for (int i = 0; i < 20 && busy; i++) begin
      step();
      if (busy) busy_cnt++;
    end
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [15:0] v);
    load    = 1'b1;
    address = a;
    din     = v;
    step();
    load    = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic start_sweep();
    clear = 1'b1;
    step();
    clear    = 1'b0;
    busy_cnt = busy ? 1 : 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd3, 16'h1234, 8'b0000_1000, 16'h1234};
    vecs[1] = '{1'b0, 3'd2, 16'h0000, 8'b0000_0000, 16'h0000};
    vecs[2] = '{1'b0, 3'd3, 16'hFFFF, 8'b0000_0000, 16'h1234};
    vecs[3] = '{1'b1, 3'd0, 16'hBEEF, 8'b0000_0001, 16'hBEEF};
    vecs[4] = '{1'b1, 3'd7, 16'h8001, 8'b1000_0000, 16'h8001};
    vecs[5] = '{1'b1, 3'd7, 16'h0042, 8'b1000_0000, 16'h0042};
    vecs[6] = '{1'b0, 3'd0, 16'h5A5A, 8'b0000_0000, 16'hBEEF};

    reset = 1'b1; din = '0; load = 1'b0; address = '0; clear = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    for (int k = 0; k < 8; k++) read_check($sformatf("reset_entry%0d", k), 3'(k), 16'h0000);
    check("reset_busy", busy, 0);
    check("reset_drop", drop, 0);

    // Table: writes and reads in IDLE
    for (int i = 0; i < 7; i++) begin
      load = vecs[i].load; address = vecs[i].addr; din = vecs[i].din;
      #1;
      check($sformatf("vec%0d_wr_sel", i), wr_sel, vecs[i].exp_sel);
      step();
      load = 1'b0;
      #1;
      check($sformatf("vec%0d_out", i), dout, vecs[i].exp_out);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Full sweep: busy for 8 cycles, entries cleared in order
    for (int k = 0; k < 8; k++) write_entry(3'(k), 16'hA000 + 16'(k));
    start_sweep();
    check("sweep_busy_start", busy, 1);
    sweep_steps(4);
    read_check("sweep_mid_entry3", 3'd3, 16'h0000);
    read_check("sweep_mid_entry4", 3'd4, 16'hA004);
    finish_sweep();
    check("sweep_busy_cycles", busy_cnt, 8);
    check("sweep_busy_end", busy, 0);
    for (int k = 0; k < 8; k++) read_check($sformatf("sweep_done_entry%0d", k), 3'(k), 16'h0000);

    // Load and clear while sweeping
    write_entry(3'd7, 16'h1111);
    start_sweep();
    sweep_steps(2);
    load = 1'b1; address = 3'd7; din = 16'hFFFF;
    #1;
    check("mid_load_wr_sel", wr_sel, 8'h00);
    sweep_steps(1);
    load = 1'b0;
    check("mid_load_drop", drop, 1);
    read_check("mid_load_entry7", 3'd7, 16'h1111);
    sweep_steps(1);
    check("mid_drop_pulse", drop, 0);
    clear = 1'b1;
    sweep_steps(1);
    clear = 1'b0;
    check("mid_clear_drop", drop, 0);
    finish_sweep();
    check("mid_clear_busy_cycles", busy_cnt, 8);
    read_check("mid_load_entry7_end", 3'd7, 16'h0000);

    // Clear and load on the same IDLE edge
    write_entry(3'd0, 16'h7777);
    clear = 1'b1; load = 1'b1; address = 3'd0; din = 16'h5555;
    #1;
    check("clr_load_wr_sel", wr_sel, 8'h00);
    step();
    clear = 1'b0; load = 1'b0;
    busy_cnt = busy ? 1 : 0;
    check("clr_load_drop", drop, 1);
    check("clr_load_busy", busy, 1);
    read_check("clr_load_no_write", 3'd0, 16'h7777);
    finish_sweep();
    check("clr_load_busy_cycles", busy_cnt, 8);
    read_check("clr_load_entry0", 3'd0, 16'h0000);

    // Reset in the middle of a sweep
    for (int k = 0; k < 8; k++) write_entry(3'(k), 16'hC000 + 16'(k));
    start_sweep();
    sweep_steps(2);
    load = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0; load = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_drop", drop, 0);
    for (int k = 0; k < 8; k++) read_check($sformatf("rst_mid_entry%0d", k), 3'(k), 16'h0000);
    write_entry(3'd0, 16'h0001);
    write_entry(3'd1, 16'hABCD);
    start_sweep();
    sweep_steps(1);
    read_check("rst_resweep_entry0", 3'd0, 16'h0000);
    read_check("rst_resweep_entry1", 3'd1, 16'hABCD);
    finish_sweep();
    check("rst_resweep_busy_cycles", busy_cnt, 8);
    read_check("rst_resweep_entry1_end", 3'd1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
